// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, FSM states and glyph addressing
// for the LCD digit renderer.
package lcd_pkg;

   localparam int GLYPH_ROWS = 16;
   localparam int GLYPH_COLS = 8;
   localparam int NUM_GLYPHS = 10;
   localparam int ROM_DEPTH  = 160;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SHIFT,
      DONE
   } state_e;

   // Non-BCD digits fold onto glyph 0 so no address reaches ROM_DEPTH.
   function automatic logic [7:0] glyph_addr(
      input logic [3:0] digit,
      input logic [3:0] row
   );
      logic [3:0] d;
      d = (int'(digit) < NUM_GLYPHS) ? digit : 4'd0;
      return {d, row};
   endfunction

endpackage

// File: rtl/lcd_row_serializer.sv
// lcd_row_serializer: shifts one glyph row byte out MSB first,
// one bit per valid/ready handshake.
module lcd_row_serializer
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [7:0] byte_i,
   input  logic       ready_i,
   output logic       valid_o,
   output logic       bit_o,
   output logic       last_bit_o,
   output logic       row_done_o
);

   logic [7:0] shreg_q, shreg_d;
   logic [3:0] cnt_q, cnt_d;
   logic       fire;

   assign valid_o    = (cnt_q != 4'd0);
   assign fire       = valid_o && ready_i;
   assign bit_o      = shreg_q[7];
   assign last_bit_o = (cnt_q == 4'd1);
   assign row_done_o = fire && last_bit_o;

   always_comb begin
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = byte_i;
         cnt_d   = 4'(GLYPH_COLS);
      end else if (fire) begin
         shreg_d = {shreg_q[6:0], 1'b0};
         cnt_d   = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= 8'h00;
         cnt_q   <= 4'd0;
      end else begin
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/lcd_digit_renderer.sv
// lcd_digit_renderer: rasterises a latched BCD value into a pixel stream.
// LCD_LEADING_ZERO_BLANK_EN: blank leading zero digits (LSD always drawn).
module lcd_digit_renderer
   import lcd_pkg::*;
#(
   parameter int                NUM_DIGITS = 4,
   parameter int                PIX_W      = 16,
   parameter logic [PIX_W-1:0]  FG_COLOR   = 16'hFFFF,
   parameter logic [PIX_W-1:0]  BG_COLOR   = 16'h0000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [4*NUM_DIGITS-1:0] digits_bcd,
   output logic                    busy,
   output logic                    done,
   output logic [7:0]              rom_addr,
   input  logic [7:0]              rom_data,
   output logic                    pix_valid,
   input  logic                    pix_ready,
   output logic [PIX_W-1:0]        pix_data,
   output logic                    pix_eol,
   output logic                    pix_last
);

   localparam logic [2:0] MSD = 3'(NUM_DIGITS - 1);

   state_e                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [3:0]              row_q, row_d;
   logic [2:0]              dig_q, dig_d;
   logic [3:0]              nib;
   logic                    blank;
   logic                    load;
   logic [7:0]              load_byte;
   logic                    ser_bit;
   logic                    last_bit;
   logic                    row_done;

   assign nib      = digits_q[{dig_q, 2'b00} +: 4];
   assign rom_addr = glyph_addr(nib, row_q);

   always_comb begin
      blank = 1'b0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
      blank = (dig_q != 3'd0);
      for (int i = 0; i < NUM_DIGITS; i++)
         if (3'(i) >= dig_q && digits_q[4*i +: 4] != 4'd0)
            blank = 1'b0;
`endif
   end

   assign load_byte = (blank || int'(nib) >= NUM_GLYPHS) ? 8'h00 : rom_data;

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      row_d    = row_q;
      dig_d    = dig_q;
      load     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               digits_d = digits_bcd;
               row_d    = 4'd0;
               dig_d    = MSD;
               state_d  = FETCH;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            load    = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (row_done) begin
               state_d = FETCH;
               if (dig_q != 3'd0) begin
                  dig_d = dig_q - 3'd1;
               end else if (row_q != 4'(GLYPH_ROWS - 1)) begin
                  dig_d = MSD;
                  row_d = row_q + 4'd1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         digits_q <= '0;
         row_q    <= 4'd0;
         dig_q    <= 3'd0;
      end else begin
         state_q  <= state_d;
         digits_q <= digits_d;
         row_q    <= row_d;
         dig_q    <= dig_d;
      end
   end

   lcd_row_serializer u_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .byte_i     (load_byte),
      .ready_i    (pix_ready),
      .valid_o    (pix_valid),
      .bit_o      (ser_bit),
      .last_bit_o (last_bit),
      .row_done_o (row_done)
   );

   assign busy     = (state_q == FETCH) || (state_q == LOAD) ||
                     (state_q == SHIFT);
   assign done     = (state_q == DONE);
   assign pix_data = ser_bit ? FG_COLOR : BG_COLOR;
   assign pix_eol  = pix_valid && last_bit && (dig_q == 3'd0);
   assign pix_last = pix_eol && (row_q == 4'(GLYPH_ROWS - 1));

endmodule

// File: tb/tb_lcd_digit_renderer.sv
// tb_lcd_digit_renderer: random-backpressure frames checked
// against a raster-order reference model and a registered ROM model.
module tb_lcd_digit_renderer;

   localparam logic [15:0] FG = 16'hFFFF;
   localparam logic [15:0] BG = 16'h0000;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] digits_bcd;
   logic        busy;
   logic        done;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_data;
   logic        pix_eol;
   logic        pix_last;

   int          checks = 0;
   int          errors = 0;
   int          pix_cnt = 0;
   int          done_cnt = 0;
   int          addr_bad = 0;
   int          cyc = 0;
   int          last_hs_cyc = -1000;
   int          done_cyc = -100;
   logic [15:0] ref_val = 16'h0;
   bit          rnd_ready = 0;
   bit          hold_pend = 0;
   logic [17:0] held;

   lcd_digit_renderer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .digits_bcd (digits_bcd),
      .busy       (busy),
      .done       (done),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_eol    (pix_eol),
      .pix_last   (pix_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered glyph ROM: byte = {digit, row}
   always @(posedge clk)
      rom_data <= (rom_addr < 8'd160) ? rom_addr : 8'hEE;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Pixel k of a frame of value v: {colour, eol, last}
   function automatic logic [17:0] model_pix(input logic [15:0] v,
                                             input int k);
      int         row, pos, p, bitn;
      logic [3:0] nib;
      logic [7:0] b;
      bit         blank;
      row  = k / 32;
      pos  = k % 32;
      p    = 3 - pos / 8;
      bitn = 7 - pos % 8;
      nib  = 4'((v >> (4 * p)) & 16'hF);
      b    = (nib > 4'd9) ? 8'h00 : 8'(int'(nib) * 16 + row);
      blank = 1'b0;
`ifdef LCD_LEADING_ZERO_BLANK_EN
      blank = (p != 0) && ((v >> (4 * p)) == 16'h0);
`endif
      if (blank) b = 8'h00;
      return {b[bitn] ? FG : BG, pos == 31, k == 511};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (rom_addr > 8'd159) addr_bad++;
         if (hold_pend) begin
            chk("stall_valid", pix_valid, 1);
            chk("stall_hold", {pix_data, pix_eol, pix_last}, held);
            hold_pend = 1'b0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", busy, 0);
         end
         if (pix_valid && pix_ready) begin
            if (pix_cnt < 512)
               chk("pix", {pix_data, pix_eol, pix_last},
                   model_pix(ref_val, pix_cnt));
            else
               chk("pix_overrun", pix_cnt, 511);
            pix_cnt++;
            if (pix_cnt == 512) last_hs_cyc = cyc;
         end else if (pix_valid) begin
            hold_pend = 1'b1;
            held = {pix_data, pix_eol, pix_last};
         end
      end
   end

   initial begin
      pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic run_frame(input logic [15:0] v, input bit rnd,
                            input int start_at, input int abort_at);
      bit injected = 1'b0;
      bit fin = 1'b0;
      @(posedge clk);
      #1;
      rnd_ready   = rnd;
      pix_cnt     = 0;
      done_cnt    = 0;
      addr_bad    = 0;
      last_hs_cyc = -1000;
      done_cyc    = -100;
      ref_val     = v;
      digits_bcd  = v;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      digits_bcd = 16'($urandom);
      chk("busy_rise", busy, 1);
      for (int n = 0; n < 4000 && !fin; n++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (abort_at >= 0 && pix_cnt >= abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("abort_valid", pix_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            repeat (20) @(posedge clk);
            #1;
            chk("abort_no_done", done_cnt, 0);
            return;
         end
         if (start_at >= 0 && pix_cnt >= start_at && !injected) begin
            start      = 1'b1;
            digits_bcd = 16'h9999;
            injected   = 1'b1;
         end
         if (done) begin
            start      = 1'b1;
            digits_bcd = 16'h8888;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk("done_start_ign", busy, 0);
            fin = 1'b1;
         end
      end
      chk("frame_fin", fin, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("pix_count", pix_cnt, 512);
      chk("done_count", done_cnt, 1);
      chk("done_latency", done_cyc - last_hs_cyc, 1);
      chk("rom_addr_max", addr_bad, 0);
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      digits_bcd = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", pix_valid, 0);
      chk("rst_eol", pix_eol, 0);
      chk("rst_last", pix_last, 0);
      chk("rst_data", pix_data, BG);
      chk("rst_addr", rom_addr, 0);
      rst = 1'b0;
      run_frame(16'h1234, 1'b0, -1, -1);
      run_frame(16'h1234, 1'b1, -1, -1);
      run_frame(16'h0A09, 1'b1, -1, -1);
      run_frame(16'h1234, 1'b0, 100, -1);
      run_frame(16'h4321, 1'b1, -1, 200);
      run_frame(16'h5678, 1'b0, -1, -1);
      run_frame(16'h0007, 1'b0, -1, -1);
      run_frame(16'h0000, 1'b1, -1, -1);
      for (int i = 0; i < 3; i++)
         run_frame(16'($urandom), 1'b1, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
